// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encodings, default memory depth and address helper.
package imem_loader_pkg;

  localparam int IMEM_DEPTH_WORDS = 4096;

  typedef enum logic [2:0] {
    LDR_ST_HDR   = 3'd0,
    LDR_ST_CHECK = 3'd1,
    LDR_ST_LOAD  = 3'd2,
    LDR_ST_FLUSH = 3'd3,
    LDR_ST_DONE  = 3'd4,
    LDR_ST_ERR   = 3'd5
  } ldr_state_e;

  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
    return {word_idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into 32-bit little-endian words; the completed word is
// presented combinationally alongside the fourth byte.
module imem_byte_packer (
  input  logic        clk_i,
  input  logic        clr_n_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_data_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (byte_en_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[31:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      lane_q  <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  // Earlier bytes have shifted down, so the newest byte lands in [31:24].
  assign word_data_o  = {byte_i, shift_q[31:8]};
  assign word_valid_o = byte_en_i && (lane_q == 2'd3);
  assign lane_o       = lane_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into
// instruction memory word by word, and holds the core in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS    = IMEM_DEPTH_WORDS,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_wr_en_o,
  output logic [31:0] imem_wr_addr_o,
  output logic [31:0] imem_wr_data_o,
  output logic        core_rst_n_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS) + 1;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH_WORDS);
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

  ldr_state_e       state_q, state_d;
  logic [31:0]      n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      idle_q, idle_d;
  logic             ready_q, ready_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;

  logic        accept;
  logic        counting;
  logic        timeout_hit;
  logic [1:0]  lane;
  logic        word_valid;
  logic [31:0] word_data;
  logic [31:0] idx_ext;

  assign accept  = byte_valid_i && byte_ready_o;
  assign idx_ext = 32'(idx_q);

  imem_byte_packer u_packer (
    .clk_i        (sys_clk_i),
    .clr_n_i      (rst_n_i && (state_q != LDR_ST_CHECK)),
    .byte_en_i    (accept),
    .byte_i       (byte_data_i),
    .lane_o       (lane),
    .word_valid_o (word_valid),
    .word_data_o  (word_data)
  );

  // The idle timer only runs once a stream has started; an accepted byte always wins.
  assign counting    = (state_q == LDR_ST_LOAD) || ((state_q == LDR_ST_HDR) && (lane != 2'd0));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !accept &&
                       ((idle_q + 32'd1) >= TIMEOUT_U);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    idle_d    = 32'd0;
    if (counting && !accept) begin
      idle_d = idle_q + 32'd1;
    end

    unique case (state_q)
      LDR_ST_HDR: begin
        if (word_valid) begin
          n_d     = word_data;
          state_d = LDR_ST_CHECK;
        end else if (timeout_hit) begin
          state_d = LDR_ST_ERR;
        end
      end
      LDR_ST_CHECK: begin
        if (n_q == 32'd0) begin
          state_d = LDR_ST_DONE;
        end else if (n_q > DEPTH_U) begin
          state_d = LDR_ST_ERR;
        end else begin
          idx_d   = '0;
          state_d = LDR_ST_LOAD;
        end
      end
      LDR_ST_LOAD: begin
        if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = word_to_byte_addr(idx_ext);
          wr_data_d = word_data;
          idx_d     = idx_q + 1'b1;
          if ((idx_ext + 32'd1) == n_q) begin
            state_d = LDR_ST_FLUSH;
          end
        end else if (timeout_hit) begin
          state_d = LDR_ST_ERR;
        end
      end
      LDR_ST_FLUSH: state_d = LDR_ST_DONE;
      LDR_ST_DONE:  state_d = LDR_ST_DONE;
      LDR_ST_ERR:   state_d = LDR_ST_ERR;
      default:      state_d = LDR_ST_HDR;
    endcase

    ready_d = (state_d == LDR_ST_HDR) || (state_d == LDR_ST_LOAD);
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      state_q   <= LDR_ST_HDR;
      n_q       <= 32'd0;
      idx_q     <= '0;
      idle_q    <= 32'd0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Ready is gated by the raw reset so it drops in the same cycle reset asserts.
  assign byte_ready_o   = ready_q && rst_n_i;
  assign imem_wr_en_o   = wr_en_q;
  assign imem_wr_addr_o = wr_addr_q;
  assign imem_wr_data_o = wr_data_q;
  assign core_rst_n_o   = (state_q == LDR_ST_DONE);
  assign load_done_o    = (state_q == LDR_ST_DONE);
  assign load_err_o     = (state_q == LDR_ST_ERR);

endmodule
